imem_arbiter: RTL and testbench

//  Shares the dual-port synchronous instruction BRAM (1-cycle read latency) between the fetch

---
 rtl/core_pkg.sv | 9 +
 rtl/imem_arbiter.sv | 140 ++++++++++++++
 tb/tb_imem_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Core-wide types and widths shared by the fetch/memory path.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {ARB_BOOT, ARB_RUN, ARB_DRAIN} imem_arb_state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_FETCH, OWN_LOAD} imem_owner_t;

endpackage

// File: rtl/imem_arbiter.sv
// Shares the dual-port instruction BRAM between fetch and the program loader.
// Latency: grants combinational, read response one cycle after the grant.
// Backpressure: a denied requester simply holds its request; fetch is starvation-bounded.
module imem_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH  = XLEN,
    parameter int INSTR_WIDTH = XLEN,
    parameter int STARVE_MAX  = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   boot_hold,

    input  logic                   f_req,
    input  logic [ADDR_WIDTH-1:0]  f_addr0,
    input  logic [ADDR_WIDTH-1:0]  f_addr1,
    input  logic                   f_flush,
    output logic                   f_gnt,
    output logic                   f_rvalid,
    output logic [INSTR_WIDTH-1:0] f_rdata0,
    output logic [INSTR_WIDTH-1:0] f_rdata1,

    input  logic                   l_req,
    input  logic                   l_we,
    input  logic [ADDR_WIDTH-1:0]  l_addr,
    input  logic [INSTR_WIDTH-1:0] l_wdata,
    output logic                   l_gnt,
    output logic                   l_rvalid,
    output logic [INSTR_WIDTH-1:0] l_rdata,

    output logic                   imem_ren,
    output logic                   imem_wen,
    output logic [ADDR_WIDTH-1:0]  imem_addr0,
    output logic [ADDR_WIDTH-1:0]  imem_addr1,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    input  logic [INSTR_WIDTH-1:0] imem_rdata0,
    input  logic [INSTR_WIDTH-1:0] imem_rdata1
);

    localparam int CW = $clog2(STARVE_MAX + 1);

    imem_arb_state_t       state;
    imem_owner_t           resp_owner;
    logic [CW-1:0]         starve_cnt;
    logic                  squash_q;
    logic [ADDR_WIDTH-1:0] addr0_q;
    logic [ADDR_WIDTH-1:0] addr1_q;
    logic                  starved;

    assign starved = (starve_cnt == CW'(STARVE_MAX));

    always_comb begin
        f_gnt = 1'b0;
        l_gnt = 1'b0;
        if (!reset) begin
            case (state)
                ARB_BOOT: l_gnt = l_req;
                ARB_RUN: begin
                    if (f_req && l_req) begin
                        f_gnt = starved;
                        l_gnt = !starved;
                    end else begin
                        f_gnt = f_req;
                        l_gnt = l_req;
                    end
                end
                default: ;
            endcase
        end
    end

    // Idle cycles keep the last granted address to avoid needless BRAM address toggling.
    always_comb begin
        imem_ren   = f_gnt | (l_gnt & ~l_we);
        imem_wen   = l_gnt & l_we;
        imem_wdata = l_wdata;
        if (f_gnt) begin
            imem_addr0 = f_addr0;
            imem_addr1 = f_addr1;
        end else if (l_gnt) begin
            imem_addr0 = l_addr;
            imem_addr1 = l_addr;
        end else begin
            imem_addr0 = addr0_q;
            imem_addr1 = addr1_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ARB_BOOT;
        end else begin
            case (state)
                ARB_BOOT:  if (!boot_hold) state <= ARB_RUN;
                ARB_RUN:   if (boot_hold) state <= ARB_DRAIN;
                default:   state <= ARB_BOOT;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (state == ARB_RUN) begin
            if (f_req && !f_gnt) begin
                if (!starved) starve_cnt <= starve_cnt + CW'(1);
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // A flush that coincides with a new fetch grant only targets the older response,
    // so it is only remembered when no new fetch was accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            resp_owner <= OWN_NONE;
            squash_q   <= 1'b0;
            addr0_q    <= '0;
            addr1_q    <= '0;
        end else begin
            if (f_gnt)                resp_owner <= OWN_FETCH;
            else if (l_gnt && !l_we)  resp_owner <= OWN_LOAD;
            else                      resp_owner <= OWN_NONE;
            squash_q <= f_flush & ~f_gnt;
            if (f_gnt || l_gnt) begin
                addr0_q <= imem_addr0;
                addr1_q <= imem_addr1;
            end
        end
    end

    assign f_rvalid = (resp_owner == OWN_FETCH) & ~f_flush & ~squash_q;
    assign l_rvalid = (resp_owner == OWN_LOAD);
    assign f_rdata0 = imem_rdata0;
    assign f_rdata1 = imem_rdata1;
    assign l_rdata  = imem_rdata0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter: directed vector table, hand sequences, then random traffic vs a model.
module tb_imem_arbiter;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        boot_hold;
    logic        f_req, f_flush, f_gnt, f_rvalid;
    logic [31:0] f_addr0, f_addr1, f_rdata0, f_rdata1;
    logic        l_req, l_we, l_gnt, l_rvalid;
    logic [31:0] l_addr, l_wdata, l_rdata;
    logic        imem_ren, imem_wen;
    logic [31:0] imem_addr0, imem_addr1, imem_wdata, imem_rdata0, imem_rdata1;

    always #5 clk = ~clk;

    imem_arbiter #(.ADDR_WIDTH(32), .INSTR_WIDTH(32), .STARVE_MAX(8)) dut (
        .clk(clk), .reset(reset), .boot_hold(boot_hold),
        .f_req(f_req), .f_addr0(f_addr0), .f_addr1(f_addr1), .f_flush(f_flush),
        .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata0(f_rdata0), .f_rdata1(f_rdata1),
        .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
        .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
        .imem_ren(imem_ren), .imem_wen(imem_wen), .imem_addr0(imem_addr0),
        .imem_addr1(imem_addr1), .imem_wdata(imem_wdata),
        .imem_rdata0(imem_rdata0), .imem_rdata1(imem_rdata1)
    );

    function automatic logic [31:0] init_word(int i);
        return 32'hA5A5_0000 + 32'(i);
    endfunction

    // 16-word synchronous BRAM, word index = addr[5:2]
    logic [31:0] mem [16];
    logic        mem_clr;
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else begin
            if (imem_wen) mem[imem_addr0[5:2]] <= imem_wdata;
            if (imem_ren) begin
                imem_rdata0 <= mem[imem_addr0[5:2]];
                imem_rdata1 <= mem[imem_addr1[5:2]];
            end
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        logic        bh, fr, fl, lr, lw;
        logic [31:0] fa0, fa1, la, lwd;
        logic        efg, elg, efv, elv;
        logic [31:0] ed0, ed1;
    } vec_t;

    function automatic vec_t mk(logic bh, logic fr, logic [31:0] fa0, logic [31:0] fa1, logic fl,
                                logic lr, logic lw, logic [31:0] la, logic [31:0] lwd,
                                logic efg, logic elg, logic efv, logic elv,
                                logic [31:0] ed0, logic [31:0] ed1);
        vec_t v;
        v.bh = bh; v.fr = fr; v.fa0 = fa0; v.fa1 = fa1; v.fl = fl;
        v.lr = lr; v.lw = lw; v.la = la; v.lwd = lwd;
        v.efg = efg; v.elg = elg; v.efv = efv; v.elv = elv; v.ed0 = ed0; v.ed1 = ed1;
        return v;
    endfunction

    task automatic drive(logic bh, logic fr, logic [31:0] fa0, logic [31:0] fa1, logic fl,
                         logic lr, logic lw, logic [31:0] la, logic [31:0] lwd);
        boot_hold = bh; f_req = fr; f_addr0 = fa0; f_addr1 = fa1; f_flush = fl;
        l_req = lr; l_we = lw; l_addr = la; l_wdata = lwd;
    endtask

    // Reference model state (abstract: mode 0=boot 1=run 2=drain, pending 0/1=fetch/2=loader)
    int          m_mode, m_starve, m_pend;
    logic [31:0] m_pd0, m_pd1;
    logic [31:0] shadow [16];

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; mem_clr = 1'b1;
        drive(1'b1, 1'b1, 32'h0, 32'h4, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        #1;
        check("rst_f_gnt", 64'(f_gnt), 64'd0);
        check("rst_l_gnt", 64'(l_gnt), 64'd0);
        check("rst_f_rvalid", 64'(f_rvalid), 64'd0);
        check("rst_l_rvalid", 64'(l_rvalid), 64'd0);
        check("rst_state", 64'(dut.state), 64'(ARB_BOOT));
        check("rst_starve", 64'(dut.starve_cnt), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0; mem_clr = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) shadow[i] = init_word(i);
        m_mode = 0; m_starve = 0; m_pend = 0; m_pd0 = '0; m_pd1 = '0;
    endtask

    vec_t vt[$];
    initial begin
        reset = 1'b1; mem_clr = 1'b1;
        drive(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        do_reset();

        // Boot load while fetch is requesting, then loader readback
        for (int k = 1; k <= 6; k++)
            vt.push_back(mk(1, 1, 32'h0, 32'h4, 0, 1, 1, 32'((k - 1) * 4), 32'(32'h1111_1111 * k),
                            0, 1, 0, 0, 32'h0, 32'h0));
        vt.push_back(mk(1, 1, 32'h0,  32'h4,  0, 1, 0, 32'h08, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0));
        vt.push_back(mk(0, 0, 32'h0,  32'h4,  0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 1, 32'h3333_3333, 32'h0));
        // Run fetch
        vt.push_back(mk(0, 1, 32'h0,  32'h4,  0, 0, 0, 32'h0,  32'h0, 1, 0, 0, 0, 32'h0, 32'h0));
        vt.push_back(mk(0, 0, 32'h0,  32'h4,  0, 0, 0, 32'h0,  32'h0, 0, 0, 1, 0, 32'h1111_1111, 32'h2222_2222));
        // Redirect: flush together with a new request
        vt.push_back(mk(0, 1, 32'h10, 32'h14, 0, 0, 0, 32'h0,  32'h0, 1, 0, 0, 0, 32'h0, 32'h0));
        vt.push_back(mk(0, 1, 32'h08, 32'h0C, 1, 0, 0, 32'h0,  32'h0, 1, 0, 0, 0, 32'h0, 32'h0));
        vt.push_back(mk(0, 0, 32'h0,  32'h4,  0, 0, 0, 32'h0,  32'h0, 0, 0, 1, 0, 32'h3333_3333, 32'h4444_4444));
        // Re-boot during back-to-back fetch
        vt.push_back(mk(0, 1, 32'h00, 32'h04, 0, 0, 0, 32'h0,  32'h0, 1, 0, 0, 0, 32'h0, 32'h0));
        vt.push_back(mk(1, 1, 32'h08, 32'h0C, 0, 0, 0, 32'h0,  32'h0, 1, 0, 1, 0, 32'h1111_1111, 32'h2222_2222));
        vt.push_back(mk(1, 1, 32'h00, 32'h04, 0, 1, 0, 32'h14, 32'h0, 0, 0, 1, 0, 32'h3333_3333, 32'h4444_4444));
        vt.push_back(mk(1, 1, 32'h00, 32'h04, 0, 1, 0, 32'h14, 32'h0, 0, 1, 0, 0, 32'h0, 32'h0));
        vt.push_back(mk(1, 0, 32'h00, 32'h04, 0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 1, 32'h6666_6666, 32'h0));
        vt.push_back(mk(0, 0, 32'h00, 32'h04, 0, 0, 0, 32'h0,  32'h0, 0, 0, 0, 0, 32'h0, 32'h0));

        foreach (vt[i]) begin
            @(negedge clk);
            drive(vt[i].bh, vt[i].fr, vt[i].fa0, vt[i].fa1, vt[i].fl,
                  vt[i].lr, vt[i].lw, vt[i].la, vt[i].lwd);
            #1;
            check($sformatf("vec%0d_f_gnt", i), 64'(f_gnt), 64'(vt[i].efg));
            check($sformatf("vec%0d_l_gnt", i), 64'(l_gnt), 64'(vt[i].elg));
            check($sformatf("vec%0d_f_rvalid", i), 64'(f_rvalid), 64'(vt[i].efv));
            check($sformatf("vec%0d_l_rvalid", i), 64'(l_rvalid), 64'(vt[i].elv));
            if (vt[i].efv) begin
                check($sformatf("vec%0d_f_rdata0", i), 64'(f_rdata0), 64'(vt[i].ed0));
                check($sformatf("vec%0d_f_rdata1", i), 64'(f_rdata1), 64'(vt[i].ed1));
            end
            if (vt[i].elv) check($sformatf("vec%0d_l_rdata", i), 64'(l_rdata), 64'(vt[i].ed0));
        end

        // Starvation: loader wins 8 cycles, fetch the 9th, loader again the 10th
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            drive(1'b0, 1'b1, 32'h0, 32'h4, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
            #1;
            check($sformatf("starve%0d_f_gnt", c), 64'(f_gnt), 64'(c == 9));
            check($sformatf("starve%0d_l_gnt", c), 64'(l_gnt), 64'(c != 9));
            if (c == 10) check("starve_cnt_cleared", 64'(dut.starve_cnt), 64'd0);
        end

        // Async reset one cycle after a fetch grant drops the response
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b1, 32'h10, 32'h14, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        #1 check("arst_pre_f_gnt", 64'(f_gnt), 64'd1);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        check("arst_f_rvalid", 64'(f_rvalid), 64'd0);
        check("arst_f_gnt", 64'(f_gnt), 64'd0);
        check("arst_state", 64'(dut.state), 64'(ARB_BOOT));
        @(negedge clk);
        reset = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        #1 check("arst_after_f_rvalid", 64'(f_rvalid), 64'd0);

        // Random traffic against the behavioural model
        do_reset();
        boot_hold = 1'b0;
        for (int n = 0; n < 1500; n++) begin
            logic efg, elg, efv, elv, bh;
            @(negedge clk);
            bh = ($urandom_range(0, 29) == 0) ? ~boot_hold : boot_hold;
            drive(bh, 1'($urandom), $urandom & 32'h3C, $urandom & 32'h3C,
                  ($urandom_range(0, 5) == 0), 1'($urandom), 1'($urandom),
                  $urandom & 32'h3C, $urandom);
            #1;
            efg = 1'b0; elg = 1'b0;
            if (m_mode == 0) elg = l_req;
            else if (m_mode == 1) begin
                if (f_req && l_req) begin
                    efg = (m_starve == 8);
                    elg = (m_starve != 8);
                end else begin
                    efg = f_req;
                    elg = l_req;
                end
            end
            efv = (m_pend == 1) && !f_flush;
            elv = (m_pend == 2);
            check("rnd_f_gnt", 64'(f_gnt), 64'(efg));
            check("rnd_l_gnt", 64'(l_gnt), 64'(elg));
            check("rnd_f_rvalid", 64'(f_rvalid), 64'(efv));
            check("rnd_l_rvalid", 64'(l_rvalid), 64'(elv));
            if (efv) begin
                check("rnd_f_rdata0", 64'(f_rdata0), 64'(m_pd0));
                check("rnd_f_rdata1", 64'(f_rdata1), 64'(m_pd1));
            end
            if (elv) check("rnd_l_rdata", 64'(l_rdata), 64'(m_pd0));

            if (m_mode == 1) m_starve = (f_req && !efg) ? ((m_starve < 8) ? m_starve + 1 : 8) : 0;
            if (efg) begin
                m_pend = 1;
                m_pd0 = shadow[f_addr0[5:2]];
                m_pd1 = shadow[f_addr1[5:2]];
            end else if (elg && !l_we) begin
                m_pend = 2;
                m_pd0 = shadow[l_addr[5:2]];
            end else begin
                m_pend = 0;
            end
            if (elg && l_we) shadow[l_addr[5:2]] = l_wdata;
            case (m_mode)
                0:       m_mode = boot_hold ? 0 : 1;
                1:       m_mode = boot_hold ? 2 : 1;
                default: m_mode = 0;
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
